// File: rtl/alu_if_pkg.sv
// Shared constants for the ALU/UART glue: state encodings, flag bit positions
// and the ALU op-code set used by the ALU and the benches.
package alu_if_pkg;

    localparam int unsigned NB_STATE = 3;
    localparam int unsigned NB_FLAGS = 2;
    localparam int unsigned NB_OP    = 6;

    localparam logic [NB_STATE-1:0] WAIT_A     = 3'd0;
    localparam logic [NB_STATE-1:0] WAIT_B     = 3'd1;
    localparam logic [NB_STATE-1:0] WAIT_OP    = 3'd2;
    localparam logic [NB_STATE-1:0] EXEC       = 3'd3;
    localparam logic [NB_STATE-1:0] SEND       = 3'd4;
    localparam logic [NB_STATE-1:0] WAIT_TX    = 3'd5;
    localparam logic [NB_STATE-1:0] SEND_FLAGS = 3'd6;
    localparam logic [NB_STATE-1:0] WAIT_FLAGS = 3'd7;

    typedef enum logic [NB_STATE-1:0] {
        ST_WAIT_A     = WAIT_A,
        ST_WAIT_B     = WAIT_B,
        ST_WAIT_OP    = WAIT_OP,
        ST_EXEC       = EXEC,
        ST_SEND       = SEND,
        ST_WAIT_TX    = WAIT_TX,
        ST_SEND_FLAGS = SEND_FLAGS,
        ST_WAIT_FLAGS = WAIT_FLAGS
    } state_e;

    localparam int unsigned FLAG_ZERO  = 0;
    localparam int unsigned FLAG_CARRY = 1;

    localparam logic [NB_OP-1:0] OP_ADD = 6'b100000;
    localparam logic [NB_OP-1:0] OP_SUB = 6'b100010;
    localparam logic [NB_OP-1:0] OP_AND = 6'b100100;
    localparam logic [NB_OP-1:0] OP_OR  = 6'b100101;
    localparam logic [NB_OP-1:0] OP_XOR = 6'b100110;
    localparam logic [NB_OP-1:0] OP_SRA = 6'b000011;
    localparam logic [NB_OP-1:0] OP_SRL = 6'b000010;
    localparam logic [NB_OP-1:0] OP_NOR = 6'b100111;

    // Packs ALU status bits into the flag layout sent over the UART.
    function automatic logic [NB_FLAGS-1:0] pack_flags(input logic zero, input logic carry);
        logic [NB_FLAGS-1:0] f;
        f             = '0;
        f[FLAG_ZERO]  = zero;
        f[FLAG_CARRY] = carry;
        return f;
    endfunction

endpackage

// File: rtl/alu_uart_interface.sv
// Collects A, B and op-code bytes from the UART RX, feeds the ALU and returns the
// result to the UART TX. Optional macro ALU_IF_FLAGS_EN also sends a {carry,zero} byte.
module alu_uart_interface
    import alu_if_pkg::*;
#(
    parameter int unsigned NB_DATA    = 8,
    parameter int unsigned NB_OP_CODE = 6
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [NB_DATA-1:0]    i_rx_data,
    input  logic                  i_rx_done,
    input  logic                  i_tx_done,
    input  logic [NB_DATA-1:0]    i_alu_result,
    input  logic                  i_alu_zero,
    input  logic                  i_alu_carry,
    output logic [NB_DATA-1:0]    o_data_a,
    output logic [NB_DATA-1:0]    o_data_b,
    output logic [NB_OP_CODE-1:0] o_op_code,
    output logic [NB_DATA-1:0]    o_tx_data,
    output logic                  o_tx_start,
    output logic                  o_busy,
    output logic                  o_rx_overrun
);

    state_e                  state_q;
    logic [NB_DATA-1:0]      data_a_q;
    logic [NB_DATA-1:0]      data_b_q;
    logic [NB_OP_CODE-1:0]   op_code_q;
    logic [NB_DATA-1:0]      tx_data_q;
    logic                    tx_start_q;
    logic                    busy_q;
    logic                    rx_overrun_q;

`ifdef ALU_IF_FLAGS_EN
    logic [NB_FLAGS-1:0]     flags_q;
`else
    logic                    unused_flags_c;
    assign unused_flags_c = i_alu_zero ^ i_alu_carry;
`endif

    // Single-process FSM; busy_q is high exactly while not collecting bytes.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= ST_WAIT_A;
            data_a_q     <= '0;
            data_b_q     <= '0;
            op_code_q    <= '0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            busy_q       <= 1'b0;
            rx_overrun_q <= 1'b0;
`ifdef ALU_IF_FLAGS_EN
            flags_q      <= '0;
`endif
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                ST_WAIT_A: begin
                    if (i_rx_done) begin
                        data_a_q     <= i_rx_data;
                        rx_overrun_q <= 1'b0;
                        state_q      <= ST_WAIT_B;
                    end
                end
                ST_WAIT_B: begin
                    if (i_rx_done) begin
                        data_b_q <= i_rx_data;
                        state_q  <= ST_WAIT_OP;
                    end
                end
                ST_WAIT_OP: begin
                    if (i_rx_done) begin
                        op_code_q <= i_rx_data[NB_OP_CODE-1:0];
                        busy_q    <= 1'b1;
                        state_q   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    tx_data_q  <= i_alu_result;
`ifdef ALU_IF_FLAGS_EN
                    flags_q    <= pack_flags(i_alu_zero, i_alu_carry);
`endif
                    tx_start_q <= 1'b1;
                    state_q    <= ST_SEND;
                end
                ST_SEND: begin
                    state_q <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    if (i_tx_done) begin
`ifdef ALU_IF_FLAGS_EN
                        tx_data_q  <= NB_DATA'(flags_q);
                        tx_start_q <= 1'b1;
                        state_q    <= ST_SEND_FLAGS;
`else
                        busy_q     <= 1'b0;
                        state_q    <= ST_WAIT_A;
`endif
                    end
                end
`ifdef ALU_IF_FLAGS_EN
                ST_SEND_FLAGS: begin
                    state_q <= ST_WAIT_FLAGS;
                end
                ST_WAIT_FLAGS: begin
                    if (i_tx_done) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_WAIT_A;
                    end
                end
`endif
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_WAIT_A;
                end
            endcase

            // Bytes arriving while an operation is in flight are dropped.
            if (busy_q && i_rx_done) begin
                rx_overrun_q <= 1'b1;
            end
        end
    end

    assign o_data_a     = data_a_q;
    assign o_data_b     = data_b_q;
    assign o_op_code    = op_code_q;
    assign o_tx_data    = tx_data_q;
    assign o_tx_start   = tx_start_q;
    assign o_busy       = busy_q;
    assign o_rx_overrun = rx_overrun_q;

endmodule
